// File: rtl/gen3_pkg.sv
// Shared constants and types for the Gen3 receive stream sequencer.
package gen3_pkg;

    localparam int unsigned LANES   = 16;
    localparam int unsigned BPL     = 4;
    localparam int unsigned BLK_CYC = 4;
    localparam int unsigned DW      = 8 * LANES * BPL;
    localparam int unsigned VW      = LANES * BPL;
    localparam int unsigned SHW     = 2 * LANES;
    localparam int unsigned CNTW    = 2;

    localparam logic [1:0] SH_DATA = 2'b10;
    localparam logic [1:0] SH_OS   = 2'b01;

    localparam logic [7:0] SDS_SYM = 8'hE1;
    localparam logic [7:0] SKP_SYM = 8'hAA;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OS   = 2'd1,
        S_DATA = 2'd2
    } gen3_state_e;

    typedef enum logic [1:0] {
        BLK_DATA = 2'd0,
        BLK_OS   = 2'd1,
        BLK_BAD  = 2'd2
    } gen3_blk_e;

endpackage

// File: rtl/gen3_sh_classify.sv
// Classifies a block from its per-lane sync headers; all lanes must agree.
module gen3_sh_classify
    import gen3_pkg::*;
(
    input  logic [SHW-1:0] i_sh,
    output logic [1:0]     o_cls
);

    logic w_all_data;
    logic w_all_os;

    // Lane-agreement check: any lane off the common code makes the block BAD.
    always_comb begin
        w_all_data = 1'b1;
        w_all_os   = 1'b1;
        for (int l = 0; l < int'(LANES); l++) begin
            if (i_sh[2*l +: 2] != SH_DATA) w_all_data = 1'b0;
            if (i_sh[2*l +: 2] != SH_OS)   w_all_os   = 1'b0;
        end
        if (w_all_data)    o_cls = BLK_DATA;
        else if (w_all_os) o_cls = BLK_OS;
        else               o_cls = BLK_BAD;
    end

endmodule

// File: rtl/gen3_rx_stream_ctrl.sv
// Gen3 receive stream sequencer: block tracking, OS/data-stream FSM, byte framing.
module gen3_rx_stream_ctrl
    import gen3_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [DW-1:0]   data_in,
    input  logic [SHW-1:0]  sh_in,
    input  logic            sh_valid,
    output logic [DW-1:0]   data_out,
    output logic [VW-1:0]   valid_out,
    output logic [SHW-1:0]  sh_out,
    output logic            ds_active,
    output logic            sds_det,
    output logic            skp_det,
    output logic            align_err,
    output logic            sh_err,
    output logic [7:0]      err_cnt
);

    logic [1:0]      r_state;
    logic            r_sds_pend;
    logic [CNTW-1:0] r_blk_cnt;
    logic            r_started;
    logic [1:0]      r_cls;
    logic [DW-1:0]   r_data_out;
    logic [VW-1:0]   r_valid_out;
    logic [SHW-1:0]  r_sh_out;
    logic            r_ds_active;
    logic            r_sds_det;
    logic            r_skp_det;
    logic            r_align_err;
    logic            r_sh_err;
    logic [7:0]      r_err_cnt;

    logic [1:0]      w_cls;
    logic [1:0]      w_cur_cls;
    logic [1:0]      w_blk_state;
    logic [1:0]      w_state_nxt;
    logic            w_pend_nxt;
    logic            w_sds;
    logic            w_skp;
    logic            w_sh_err;
    logic            w_early;
    logic            w_late;
    logic            w_align;
    logic            w_valid_nxt;
    logic [CNTW-1:0] w_blk_cnt_nxt;

    gen3_sh_classify u_classify (
        .i_sh  (sh_in),
        .o_cls (w_cls)
    );

    // Block cadence: a block start is expected exactly when the counter wraps to 0.
    always_comb begin
        w_early = r_started && sh_valid && (r_blk_cnt != '0);
        w_late  = r_started && !sh_valid && (r_blk_cnt == '0);
        w_align = w_early || w_late;
        if (sh_valid)
            w_blk_cnt_nxt = CNTW'(1);
        else if (r_blk_cnt == CNTW'(BLK_CYC - 1))
            w_blk_cnt_nxt = '0;
        else
            w_blk_cnt_nxt = r_blk_cnt + CNTW'(1);
    end

    // Next-state and pulse decode; transitions only take effect at block starts.
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_sds_pend;
        w_sds       = 1'b0;
        w_skp       = 1'b0;
        w_sh_err    = 1'b0;
        w_cur_cls   = sh_valid ? w_cls : r_cls;

        // State in which the block starting now is processed.
        if (r_state == S_IDLE)
            w_blk_state = S_OS;
        else if ((r_state == S_OS) && r_sds_pend)
            w_blk_state = S_DATA;
        else
            w_blk_state = r_state;

        if (sh_valid) begin
            if (w_cls == BLK_BAD) w_sh_err = 1'b1;
            if (en) begin
                w_pend_nxt = 1'b0;
                case (w_blk_state)
                    S_DATA: w_state_nxt = (w_cls == BLK_DATA) ? S_DATA : S_OS;
                    default: begin
                        if (w_cls == BLK_DATA) w_sh_err = 1'b1;
                        w_state_nxt = S_OS;
                    end
                endcase
                if (w_cls == BLK_OS) begin
                    if (data_in[7:0] == SDS_SYM) begin
                        w_sds      = 1'b1;
                        w_pend_nxt = 1'b1;
                    end
                    if (data_in[7:0] == SKP_SYM) w_skp = 1'b1;
                end
            end
        end

        if (!en) begin
            w_state_nxt = S_IDLE;
            w_pend_nxt  = 1'b0;
        end

        w_valid_nxt = (w_state_nxt == S_DATA) && (w_cur_cls == BLK_DATA);
    end

    // State, block tracking and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sds_pend  <= 1'b0;
            r_blk_cnt   <= '0;
            r_started   <= 1'b0;
            r_cls       <= BLK_BAD;
            r_data_out  <= '0;
            r_valid_out <= '0;
            r_sh_out    <= '0;
            r_ds_active <= 1'b0;
            r_sds_det   <= 1'b0;
            r_skp_det   <= 1'b0;
            r_align_err <= 1'b0;
            r_sh_err    <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sds_pend  <= w_pend_nxt;
            r_blk_cnt   <= w_blk_cnt_nxt;
            // A missed block start drops tracking until the next sh_valid.
            if (sh_valid)    r_started <= 1'b1;
            else if (w_late) r_started <= 1'b0;
            if (sh_valid) begin
                r_cls    <= w_cls;
                r_sh_out <= sh_in;
            end
            r_data_out  <= data_in;
            r_valid_out <= {VW{w_valid_nxt}};
            r_ds_active <= (w_state_nxt == S_DATA);
            r_sds_det   <= w_sds;
            r_skp_det   <= w_skp;
            r_align_err <= w_align;
            r_sh_err    <= w_sh_err;
            if ((w_align || w_sh_err) && (r_err_cnt != 8'hFF))
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign sh_out    = r_sh_out;
    assign ds_active = r_ds_active;
    assign sds_det   = r_sds_det;
    assign skp_det   = r_skp_det;
    assign align_err = r_align_err;
    assign sh_err    = r_sh_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_gen3_rx_stream_ctrl.sv
// Directed testbench for gen3_rx_stream_ctrl.
module tb_gen3_rx_stream_ctrl;

    localparam logic [31:0] SH_D   = 32'hAAAA_AAAA;
    localparam logic [31:0] SH_O   = 32'h5555_5555;
    localparam logic [31:0] SH_00  = 32'h0000_0000;
    localparam logic [31:0] SH_L5  = 32'hAAAA_A6AA;
    localparam logic [63:0] V_ALL  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [511:0] data_in;
    logic [31:0]  sh_in;
    logic         sh_valid;
    logic [511:0] data_out;
    logic [63:0]  valid_out;
    logic [31:0]  sh_out;
    logic         ds_active, sds_det, skp_det, align_err, sh_err;
    logic [7:0]   err_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] seq = 32'h0;

    gen3_rx_stream_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .data_in(data_in), .sh_in(sh_in),
        .sh_valid(sh_valid), .data_out(data_out), .valid_out(valid_out),
        .sh_out(sh_out), .ds_active(ds_active), .sds_det(sds_det),
        .skp_det(skp_det), .align_err(align_err), .sh_err(sh_err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; returns 1 time unit after the sampling edge.
    task automatic beat(input logic sv, input logic [31:0] sh, input logic [7:0] b0);
        @(negedge clk);
        seq       = seq + 32'd1;
        data_in   = {16{seq}};
        data_in[7:0] = b0;
        sh_valid  = sv;
        sh_in     = sh;
        @(posedge clk);
        #1;
    endtask

    task automatic blk(input logic [31:0] sh, input logic [7:0] b0);
        beat(1'b1, sh, b0);
        for (int i = 0; i < 3; i++) beat(1'b0, sh, 8'h00);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; sh_valid = 1'b0; sh_in = SH_D;
        data_in = {16{32'hDEAD_BEEF}};
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (data_out !== 512'h0) begin $display("FAIL reset_data got %h want 0", data_out[31:0]); n_errors++; end
        n_checks++;
        if ({valid_out, sh_out, err_cnt} !== 104'h0) begin
            $display("FAIL reset_out valid=%h sh=%h cnt=%h want 0", valid_out, sh_out, err_cnt); n_errors++; end
        n_checks++;
        if ({ds_active, sds_det, skp_det, align_err, sh_err} !== 5'b0) begin
            $display("FAIL reset_flags got %b want 00000", {ds_active, sds_det, skp_det, align_err, sh_err}); n_errors++; end
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
    endtask

    task automatic test_sds_stream();
        int vcount = 0;
        beat(1'b1, SH_O, 8'hE1);
        n_checks++;
        if (sds_det !== 1'b1 || valid_out !== 64'h0 || ds_active !== 1'b0) begin
            $display("FAIL sds_block sds=%b valid=%h ds=%b want 1/0/0", sds_det, valid_out, ds_active); n_errors++; end
        n_checks++;
        if (sh_out !== SH_O) begin $display("FAIL sds_sh_out got %h want %h", sh_out, SH_O); n_errors++; end
        for (int i = 0; i < 3; i++) begin
            beat(1'b0, SH_O, 8'h00);
            n_checks++;
            if (sds_det !== 1'b0 || valid_out !== 64'h0) begin
                $display("FAIL sds_tail beat %0d sds=%b valid=%h want 0/0", i, sds_det, valid_out); n_errors++; end
        end
        for (int i = 0; i < 12; i++) begin
            beat((i % 4) == 0, SH_D, 8'h3C);
            if (valid_out === V_ALL) vcount++;
            n_checks++;
            if (valid_out !== V_ALL || ds_active !== 1'b1 || sds_det !== 1'b0 || align_err !== 1'b0) begin
                $display("FAIL data_beat %0d valid=%h ds=%b sds=%b aerr=%b want ones/1/0/0",
                         i, valid_out, ds_active, sds_det, align_err); n_errors++; end
            n_checks++;
            if (data_out !== data_in) begin
                $display("FAIL data_out beat %0d got %h want %h", i, data_out[31:0], data_in[31:0]); n_errors++; end
        end
        n_checks++;
        if (sh_out !== SH_D) begin $display("FAIL data_sh_out got %h want %h", sh_out, SH_D); n_errors++; end
        // Stream ends on a SKP ordered set.
        beat(1'b1, SH_O, 8'hAA);
        if (valid_out === V_ALL) vcount++;
        n_checks++;
        if (skp_det !== 1'b1 || valid_out !== 64'h0 || ds_active !== 1'b0 || sds_det !== 1'b0) begin
            $display("FAIL skp_exit skp=%b valid=%h ds=%b sds=%b want 1/0/0/0", skp_det, valid_out, ds_active, sds_det); n_errors++; end
        for (int i = 0; i < 3; i++) begin
            beat(1'b0, SH_O, 8'h00);
            if (valid_out === V_ALL) vcount++;
            n_checks++;
            if (valid_out !== 64'h0 || skp_det !== 1'b0 || ds_active !== 1'b0) begin
                $display("FAIL skp_tail beat %0d valid=%h skp=%b ds=%b want 0/0/0", i, valid_out, skp_det, ds_active); n_errors++; end
        end
        n_checks++;
        if (vcount != 12) begin $display("FAIL valid_count got %0d want 12", vcount); n_errors++; end
        n_checks++;
        if (err_cnt !== 8'd0) begin $display("FAIL stream_err_cnt got %0d want 0", err_cnt); n_errors++; end
    endtask

    task automatic test_lane_mismatch();
        blk(SH_O, 8'hE1);
        blk(SH_D, 8'h11);
        n_checks++;
        if (valid_out !== V_ALL) begin $display("FAIL mm_pre valid=%h want ones", valid_out); n_errors++; end
        beat(1'b1, SH_L5, 8'h22);
        n_checks++;
        if (sh_err !== 1'b1 || valid_out !== 64'h0 || ds_active !== 1'b0 || err_cnt !== 8'd1) begin
            $display("FAIL lane_mismatch sherr=%b valid=%h ds=%b cnt=%0d want 1/0/0/1",
                     sh_err, valid_out, ds_active, err_cnt); n_errors++; end
        for (int i = 0; i < 3; i++) beat(1'b0, SH_L5, 8'h00);
        n_checks++;
        if (sh_err !== 1'b0 || valid_out !== 64'h0) begin
            $display("FAIL mm_tail sherr=%b valid=%h want 0/0", sh_err, valid_out); n_errors++; end
        // Plain OS block: back in S_OS, no further errors.
        blk(SH_O, 8'h00);
        n_checks++;
        if (err_cnt !== 8'd1 || ds_active !== 1'b0) begin
            $display("FAIL mm_after cnt=%0d ds=%b want 1/0", err_cnt, ds_active); n_errors++; end
    endtask

    task automatic test_align();
        beat(1'b1, SH_O, 8'h00);
        beat(1'b0, SH_O, 8'h00);
        beat(1'b1, SH_O, 8'h00);
        n_checks++;
        if (align_err !== 1'b1 || sh_err !== 1'b0 || err_cnt !== 8'd2) begin
            $display("FAIL early_start aerr=%b sherr=%b cnt=%0d want 1/0/2", align_err, sh_err, err_cnt); n_errors++; end
        for (int i = 0; i < 11; i++) begin
            beat((i % 4) == 3, SH_O, 8'h00);
            n_checks++;
            if (align_err !== 1'b0) begin $display("FAIL resync beat %0d aerr=%b want 0", i, align_err); n_errors++; end
        end
        n_checks++;
        if (err_cnt !== 8'd2) begin $display("FAIL resync_cnt got %0d want 2", err_cnt); n_errors++; end
    endtask

    task automatic test_saturate();
        for (int b = 1; b <= 300; b++) begin
            beat(1'b1, SH_00, 8'h00);
            if (b == 1 || b == 252) begin
                n_checks++;
                if (sh_err !== 1'b1 || err_cnt !== 8'(b + 2)) begin
                    $display("FAIL sat_block %0d sherr=%b cnt=%0d want 1/%0d", b, sh_err, err_cnt, b + 2); n_errors++; end
            end
            for (int i = 0; i < 3; i++) beat(1'b0, SH_00, 8'h00);
        end
        n_checks++;
        if (err_cnt !== 8'hFF || align_err !== 1'b0) begin
            $display("FAIL saturate cnt=%h aerr=%b want ff/0", err_cnt, align_err); n_errors++; end
    endtask

    task automatic test_rst_mid();
        blk(SH_O, 8'hE1);
        beat(1'b1, SH_D, 8'h01);
        beat(1'b0, SH_D, 8'h02);
        n_checks++;
        if (valid_out !== V_ALL || ds_active !== 1'b1) begin
            $display("FAIL rst_pre valid=%h ds=%b want ones/1", valid_out, ds_active); n_errors++; end
        rst = 1'b1;
        #1;
        n_checks++;
        if (valid_out !== 64'h0 || ds_active !== 1'b0 || err_cnt !== 8'h0 || data_out !== 512'h0 || sh_out !== 32'h0) begin
            $display("FAIL rst_mid valid=%h ds=%b cnt=%h sh=%h want all 0", valid_out, ds_active, err_cnt, sh_out); n_errors++; end
        @(negedge clk);
        rst = 1'b0;
        beat(1'b1, SH_O, 8'hE1);
        n_checks++;
        if (align_err !== 1'b0 || sds_det !== 1'b1 || err_cnt !== 8'h0) begin
            $display("FAIL rst_fresh aerr=%b sds=%b cnt=%0d want 0/1/0", align_err, sds_det, err_cnt); n_errors++; end
        for (int i = 0; i < 3; i++) beat(1'b0, SH_O, 8'h00);
    endtask

    task automatic test_en_drop();
        beat(1'b1, SH_D, 8'h05);
        beat(1'b0, SH_D, 8'h06);
        n_checks++;
        if (valid_out !== V_ALL || ds_active !== 1'b1) begin
            $display("FAIL en_pre valid=%h ds=%b want ones/1", valid_out, ds_active); n_errors++; end
        en = 1'b0;
        beat(1'b0, SH_D, 8'h07);
        n_checks++;
        if (valid_out !== 64'h0 || ds_active !== 1'b0 || data_out !== data_in) begin
            $display("FAIL en_drop valid=%h ds=%b want 0/0", valid_out, ds_active); n_errors++; end
        beat(1'b0, SH_D, 8'h08);
        beat(1'b1, SH_D, 8'h09);
        n_checks++;
        if (align_err !== 1'b0 || sh_err !== 1'b0 || valid_out !== 64'h0 || err_cnt !== 8'h0) begin
            $display("FAIL en_off_track aerr=%b sherr=%b valid=%h cnt=%0d want 0/0/0/0",
                     align_err, sh_err, valid_out, err_cnt); n_errors++; end
        for (int i = 0; i < 3; i++) beat(1'b0, SH_D, 8'h00);
        n_checks++;
        if (ds_active !== 1'b0 || valid_out !== 64'h0) begin
            $display("FAIL en_off_idle ds=%b valid=%h want 0/0", ds_active, valid_out); n_errors++; end
    endtask

    initial begin
        test_reset();
        test_sds_stream();
        test_lane_mismatch();
        test_align();
        test_saturate();
        test_rst_mid();
        test_en_drop();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gen3_rx_stream_ctrl.md
Name: gen3_rx_stream_ctrl

Overview:
- Gen3 (128b/130b) receive stream sequencer that sits immediately upstream of Gen3_DataPath.
- Tracks block boundaries and per-lane sync headers, then runs the ordered-set / data-stream state machine (SDS entry, ordered-set exit).
- Drives the datapath's per-byte valid[63:0] and syncHeader[31:0] inputs, plus registered data, so that only data-stream bytes are framed.
- Reports alignment and sync-header errors to the LTSSM.

Parameters:
- LANES, 16, lane count; one sync-header pair per lane.
- BPL, 4, bytes per lane per clock. Data width is 8*LANES*BPL = 512.
- BLK_CYC, 4, clocks per 128b block (16/BPL).
- SDS_SYM, 8'hE1, first symbol of an SDS ordered set.
- SKP_SYM, 8'hAA, first symbol of a SKP ordered set.

Ports:
- clk  in  1  datapath clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  stream processing enable from LTSSM (Recovery/L0).
- data_in  in  512  lane data; byte i = 4*lane+k (lane 0..15, k 0..3).
- sh_in  in  32  sync headers; bits [2l+1:2l] = lane l. Sampled only when sh_valid=1.
- sh_valid  in  1  first clock of a new block from the block aligner.
- data_out  out  512  data_in delayed 1 clock; to Gen3_DataPath Data_in.
- valid_out  out  64  per-byte valid; to Gen3_DataPath valid.
- sh_out  out  32  latched block headers, held for the whole block; to Gen3_DataPath syncHeader.
- ds_active  out  1  state is S_DATA.
- sds_det  out  1  pulse on SDS block.
- skp_det  out  1  pulse on SKP block.
- align_err  out  1  pulse on an early or late block start.
- sh_err  out  1  pulse on an invalid or lane-mismatched header.
- err_cnt  out  8  saturating count of align_err|sh_err events.

Behaviour:
- Reset (async, rst=1):
  - state=S_IDLE, blk_cnt=0.
  - All outputs 0, including data_out, sh_out and err_cnt.
- Latency: every output is registered, one clock after the sampled inputs.
- Header codes:
  - 2'b10 = data block.
  - 2'b01 = ordered-set block.
  - 2'b00 and 2'b11 are invalid.
  - A block is classed DATA or OS only if all lanes agree; otherwise it is BAD.
- Block counter blk_cnt (2-bit):
  - sh_valid=1 forces blk_cnt to 1 next clock.
  - Otherwise blk_cnt increments mod BLK_CYC.
  - sh_valid with blk_cnt!=0, or blk_cnt==0 without sh_valid (after the first block), pulses align_err.
  - In both error cases the block starts where sh_valid is seen (resync).
- Block class and sh_out are latched on sh_valid and held until the next sh_valid.
- States:
  - S_IDLE: en=0 forces this state from any state (next clock). en=1 goes to S_OS on the next sh_valid.
  - S_OS:
    - OS block with lane-0 byte0 (data_in[7:0]) == SDS_SYM: sds_det=1, go to S_DATA at the next block start.
    - OS block with lane-0 byte0 == SKP_SYM: skp_det=1.
    - DATA block in S_OS: sh_err=1, stay in S_OS.
  - S_DATA:
    - DATA block: valid_out=64'hFFFF_FFFF_FFFF_FFFF for all 4 clocks.
    - OS block: valid_out=0 for that block and state goes to S_OS (stream end, EDS already seen by framing). SDS/SKP detection still applies to that same block.
    - BAD block: sh_err=1, valid_out=0, go to S_OS.
- valid_out is 0 in every state other than S_DATA.
- A BAD block in any state pulses sh_err.
- Simultaneous align_err and sh_err: both pulse; err_cnt increments by 1 only and saturates at 8'hFF.
- en falling mid-block: valid_out=0 from the next clock; the blk_cnt tracking continues.
- rst mid-block: immediate clear; the next sh_valid starts fresh.

Decomposition:
- Package gen3_pkg holds:
  - SH_DATA=2'b10, SH_OS=2'b01.
  - SDS_SYM, SKP_SYM.
  - State enum {S_IDLE, S_OS, S_DATA}.
  - Block-class enum {BLK_DATA, BLK_OS, BLK_BAD}.
- One sub-module, gen3_sh_classify: combinational lane-agreement check, sh_in → block class.

Test Plan:
- en=1; OS block with byte0=8'hE1, then 3 DATA blocks → sds_det pulses once; ds_active=1 from the first data block; valid_out all-ones for exactly 12 clocks, each 1 clock after the input.
- Data stream, then OS block with byte0=8'hAA → valid_out=0 for that block; skp_det=1; state returns to S_OS; ds_active=0.
- In S_DATA, lane 5 header = 2'b01 while other lanes are 2'b10 → sh_err pulse; valid_out=0; err_cnt=1; state S_OS.
- sh_valid asserted at blk_cnt=2 → align_err pulse; blk_cnt resyncs; following blocks on a 4-clock cadence produce no further errors.
- 300 consecutive header-00 blocks → err_cnt saturates at 8'hFF.
- rst pulsed mid-data-block, and separately en dropped mid-block → outputs 0 immediately (rst) or next clock (en); state S_IDLE.
